// File: rtl/uart_ram_cmd_ctrl.sv
// +-----------------------------------------------------------------------------+
// | uart_ram_cmd_ctrl: parses UART 'W' addr data / 'R' addr commands onto a     |
// | 256x8 RAM port, returns read bytes over valid/ready. Option: CMD_TIMEOUT_EN |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module uart_ram_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 12000000,
  parameter logic [7:0]  OP_WRITE       = 8'h57,
  parameter logic [7:0]  OP_READ        = 8'h52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] ram_address,
  output logic [7:0] ram_data_in,
  output logic       ram_write_enable,
  input  logic [7:0] ram_data_out,
  output logic       busy,
  output logic       cmd_error
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_GET_ADDR   = 3'd1,
    S_GET_DATA   = 3'd2,
    S_WRITE      = 3'd3,
    S_READ_ISSUE = 3'd4,
    S_READ_CAP   = 3'd5,
    S_SEND       = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] ram_address_q, ram_address_d;
  logic       ram_we_q, ram_we_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       err_q, err_d;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned c_to_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT_CYCLES);
  logic [c_to_w-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    ram_address_d = ram_address_q;
    ram_we_d      = 1'b0;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    err_d         = 1'b0;
`ifdef CMD_TIMEOUT_EN
    cnt_d         = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            op_d    = rx_data;
            state_d = S_GET_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_valid) begin
          addr_d = rx_data;
          if (op_q == OP_READ) begin
            // Address is registered onto the RAM port as READ_ISSUE begins.
            ram_address_d = rx_data;
            state_d       = S_READ_ISSUE;
          end else begin
            state_d = S_GET_DATA;
          end
        end
      end
      S_GET_DATA: begin
        if (rx_valid) begin
          data_d        = rx_data;
          ram_address_d = addr_q;
          ram_we_d      = 1'b1;
          state_d       = S_WRITE;
        end
      end
      S_WRITE: begin
        err_d   = rx_valid;
        state_d = S_IDLE;
      end
      S_READ_ISSUE: begin
        err_d   = rx_valid;
        state_d = S_READ_CAP;
      end
      S_READ_CAP: begin
        err_d      = rx_valid;
        tx_data_d  = ram_data_out;
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        err_d = rx_valid;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CMD_TIMEOUT_EN
    // Inter-byte watchdog: abandons a stalled command before any RAM access.
    if ((state_q == S_GET_ADDR || state_q == S_GET_DATA) && !rx_valid) begin
      if (cnt_q == c_to_max) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      ram_address_q <= '0;
      ram_we_q      <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      ram_address_q <= ram_address_d;
      ram_we_q      <= ram_we_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      err_q         <= err_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign tx_data          = tx_data_q;
  assign tx_valid         = tx_valid_q;
  assign ram_address      = ram_address_q;
  assign ram_data_in      = data_q;
  assign ram_write_enable = ram_we_q;
  assign busy             = (state_q != S_IDLE);
  assign cmd_error        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_ram_cmd_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_uart_ram_cmd_ctrl: directed bench with RAM model and write/read         |
// | scoreboards for uart_ram_cmd_ctrl.                                          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_ram_cmd_ctrl;

  localparam logic [7:0] c_op_w = 8'h57;
  localparam logic [7:0] c_op_r = 8'h52;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_write_enable;
  logic [7:0] ram_data_out = 8'h00;
  logic       busy;
  logic       cmd_error;

  int n_vec = 0;
  int n_err = 0;
  int err_pulses = 0;
  int xfers = 0;

  logic [7:0]  mem [256];
  logic [15:0] wq [$];
  logic [7:0]  tq [$];
  logic [15:0] exp_w;
  logic [7:0]  exp_t;

  always #5 clk = ~clk;

  uart_ram_cmd_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out),
    .busy             (busy),
    .cmd_error        (cmd_error)
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
  end

  // 256x8 synchronous RAM; read output frozen during writes
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
    else                  ram_data_out <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_write_enable) begin
      chk("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        exp_w = wq.pop_front();
        chk("wr_addr_data", {16'h0, ram_address, ram_data_in}, {16'h0, exp_w});
      end
    end
    if (tx_valid && tx_ready) begin
      xfers++;
      chk("tx_expected", 32'(tq.size() != 0), 32'd1);
      if (tq.size() != 0) begin
        exp_t = tq.pop_front();
        chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_t});
      end
    end
    if (cmd_error) err_pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    wq.push_back({a, d});
    send_byte(c_op_w);
    send_byte(a);
    send_byte(d);
    chk("wr_strobe", {15'h0, ram_write_enable, ram_address, ram_data_in}, {15'h0, 1'b1, a, d});
    step();
    chk("wr_done", {30'h0, ram_write_enable, busy}, 32'h0);
  endtask

  task automatic read_start(input logic [7:0] a, input logic [7:0] e);
    tq.push_back(e);
    send_byte(c_op_r);
    send_byte(a);
    chk("rd_lat1", {30'h0, tx_valid, busy}, 32'h1);
    step();
    chk("rd_lat2", {31'h0, tx_valid}, 32'h0);
    step();
    chk("rd_valid", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, e});
  endtask

  task automatic read_finish();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("rd_after", {30'h0, tx_valid, busy}, 32'h0);
  endtask

  int e0;
  int x0;
  int k;

  initial begin
    step();
    chk("reset_outputs",
        {4'h0, tx_data, tx_valid, ram_address, ram_data_in, ram_write_enable, busy, cmd_error},
        32'h0);
    step();
    rst = 1'b0;

    // write then read back
    do_write(8'h10, 8'hA5);
    read_start(8'h10, 8'hA5);
    read_finish();

    // backpressure on the top address
    do_write(8'hFF, 8'h3C);
    read_start(8'hFF, 8'h3C);
    x0 = xfers;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("bp_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h3C});
    end
    read_finish();
    step(2);
    chk("bp_one_xfer", 32'(xfers - x0), 32'd1);

    // bad opcode in IDLE
    e0 = err_pulses;
    send_byte(8'h41);
    chk("bad_op", {29'h0, cmd_error, busy, ram_write_enable}, 32'h4);
    step();
    chk("bad_op_pulse", {31'h0, cmd_error}, 32'h0);
    chk("bad_op_count", 32'(err_pulses - e0), 32'd1);

    // byte dropped while SEND waits
    read_start(8'h10, 8'hA5);
    step(3);
    send_byte(c_op_w);
    chk("send_drop", {21'h0, cmd_error, busy, tx_valid, tx_data}, {21'h0, 3'b111, 8'hA5});
    step();
    chk("send_drop_hold", {22'h0, cmd_error, tx_valid, tx_data}, {22'h0, 2'b01, 8'hA5});
    read_finish();
    read_start(8'h10, 8'hA5);
    read_finish();

    // reset mid-command
    send_byte(c_op_w);
    send_byte(8'h20);
    rst = 1'b1;
    step();
    chk("rst_mid",
        {4'h0, tx_data, tx_valid, ram_address, ram_data_in, ram_write_enable, busy, cmd_error},
        32'h0);
    rst = 1'b0;
    e0 = err_pulses;
    send_byte(8'h33);
    chk("rst_then_bad", {30'h0, cmd_error, busy}, 32'h2);
    step();
    chk("rst_bad_count", 32'(err_pulses - e0), 32'd1);
    read_start(8'h20, 8'h20 ^ 8'h5A);
    read_finish();

    // stalled command
    e0 = err_pulses;
    send_byte(c_op_w);
`ifdef CMD_TIMEOUT_EN
    k = 0;
    while (busy && k < 130) begin
      step();
      k++;
    end
    chk("to_busy_fall", {31'h0, busy}, 32'h0);
    chk("to_err", 32'(err_pulses - e0), 32'd1);
`else
    step(150);
    chk("no_to_busy", {30'h0, busy, cmd_error}, 32'h2);
    chk("no_to_err", 32'(err_pulses - e0), 32'd0);
    wq.push_back(16'h0011);
    send_byte(8'h00);
    send_byte(8'h11);
    step();
    chk("no_to_done", {31'h0, busy}, 32'h0);
`endif

    step(3);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("tq_empty", 32'(tq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_ram_cmd_ctrl.md
Name: uart_ram_cmd_ctrl

Overview:
- Command initiator for the 256x8 synchronous RAM block.
- Parses a byte stream from the UART receiver into write/read commands and drives the RAM port.
- Returns read data to the UART transmitter through a valid/ready handshake.
- Sits between uart_rx, ram_block and uart_tx in the UART demo top level.

Parameters:
- TIMEOUT_CYCLES, 12000000, idle cycles allowed between bytes of one command (used only with CMD_TIMEOUT_EN).
- OP_WRITE, 8'h57, opcode byte 'W': followed by address byte, then data byte.
- OP_READ, 8'h52, opcode byte 'R': followed by address byte.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe; rx_data valid
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data valid; held until accepted
- tx_ready  input  1  transmitter accepts when tx_valid && tx_ready
- ram_address  output  8  RAM address
- ram_data_in  output  8  RAM write data
- ram_write_enable  output  1  RAM write strobe
- ram_data_out  input  8  RAM registered read data
- busy  output  1  high in any state other than IDLE
- cmd_error  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset:
  - All outputs are 0 on the first edge with rst=1.
  - State returns to IDLE and the opcode, address and data registers clear.
  - Reset mid-command abandons the command and never writes the RAM.
  - Reset while tx_valid=1 drops tx_valid on that edge.
- States: IDLE, GET_ADDR, GET_DATA, WRITE, READ_ISSUE, READ_CAP, SEND.
- IDLE:
  - rx_valid with OP_WRITE or OP_READ latches the opcode -> GET_ADDR.
  - rx_valid with any other byte pulses cmd_error and stays in IDLE.
- GET_ADDR:
  - On rx_valid, latch address.
  - Opcode W -> GET_DATA; opcode R -> READ_ISSUE.
- GET_DATA: on rx_valid, latch data -> WRITE.
- WRITE:
  - Exactly one cycle with ram_write_enable=1, ram_address=addr, ram_data_in=data -> IDLE.
- READ_ISSUE:
  - One cycle with ram_write_enable=0 and ram_address=addr.
  - The RAM registers its output on this cycle's closing edge -> READ_CAP.
- READ_CAP:
  - Sample ram_data_out into tx_data and set tx_valid=1 -> SEND.
  - Read latency is two cycles from the address byte strobe to tx_valid rising.
- SEND:
  - tx_valid and tx_data stay stable until the cycle tx_ready=1.
  - On that cycle the byte is accepted; tx_valid=0 on the next cycle -> IDLE.
- Outside WRITE, ram_write_enable is always 0. The RAM does not update its read output during writes, and the controller never relies on ram_data_out except in READ_CAP.
- ram_address holds its last value outside WRITE and READ_ISSUE.
- rx_valid arriving in WRITE, READ_ISSUE, READ_CAP or SEND: byte dropped, cmd_error pulses, state unaffected.
- Any rx_valid in GET_ADDR or GET_DATA is an operand, including opcode values. There is no resynchronisation by value.
- Address and data are full 8-bit; no wrap logic is needed, 8'hFF is a valid address.
- busy=0 only in IDLE.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in GET_ADDR and GET_DATA and clears on every rx_valid.
  - On reaching TIMEOUT_CYCLES with no byte, cmd_error pulses and the state returns to IDLE with no RAM access.
  - The counter is held at 0 in all other states.
- When undefined: no counter exists and the controller waits indefinitely for operand bytes.

Test Plan:
- Write then read:
  - Stimulus: bytes 57,10,A5, then 52,10.
  - Response: one-cycle ram_write_enable with address 10 and data A5; tx_valid rises two cycles after the address-byte strobe with tx_data=A5; busy=0 after handshake.
- Backpressure:
  - Stimulus: read 52,FF (RAM[FF]=3C); tx_ready held low 50 cycles, then high 1 cycle.
  - Response: tx_valid=1 and tx_data=3C stable throughout; exactly one transfer.
- Bad opcode:
  - Stimulus: byte 41 in IDLE.
  - Response: one-cycle cmd_error; busy stays 0; no RAM write.
- Drop during SEND:
  - Stimulus: 57 sent while SEND is waiting on tx_ready.
  - Response: cmd_error pulse; after handshake state is IDLE, and the next 52,10 still reads correctly.
- Reset mid-command:
  - Stimulus: 57,20, rst for 1 cycle, then 33.
  - Response: no write to address 20; 33 is treated as a bad opcode (cmd_error).
- Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100):
  - Stimulus: 57 followed by 100 idle cycles.
  - Response: cmd_error pulse, busy falls, no write.
  - Without the macro: busy stays 1.
